// File: rtl/square_sum_stepper.sv
// Steps through every (a,b) operand pair, one pair per rising edge of a slow square wave,
// computing a^2 + b^2 with an iterative shift-add multiplier and offering it on valid/ready.
module square_sum_stepper #(
  parameter int unsigned W = 4
) (
  input  logic           clk_in,
  input  logic           rst,
  input  logic           slow_clk,
  input  logic           enable,
  input  logic           out_ready,
  output logic [W-1:0]   op_a,
  output logic [W-1:0]   op_b,
  output logic [2*W:0]   sum,
  output logic           sum_valid,
  output logic           busy,
  output logic           wrap,
  output logic [7:0]     missed_ticks
);

  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(W - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StSqA, StSqB, StAdd, StHold} state_e;

  state_e            state_q, state_d;
  logic              sync1_q, sync2_q, edge_q;
  logic [W-1:0]      cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [W-1:0]      op_a_q, op_a_d, op_b_q, op_b_d;
  logic [2*W-1:0]    acc_q, acc_d, sq_a_q, sq_a_d, sq_b_q, sq_b_d;
  logic [2*W:0]      sum_q, sum_d;
  logic [CntW-1:0]   bit_q, bit_d;
  logic              wrap_q, wrap_d;
  logic [7:0]        missed_q, missed_d;
  logic              tick;
  logic [W-1:0]      mult;
  logic [2*W-1:0]    part, acc_next;

  // slow_clk is asynchronous data: two-flop synchronizer, then edge detect on the clean copy.
  assign tick = sync2_q & ~edge_q;

  always_comb begin
    state_d  = state_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    acc_d    = acc_q;
    sq_a_d   = sq_a_q;
    sq_b_d   = sq_b_q;
    sum_d    = sum_q;
    bit_d    = bit_q;
    wrap_d   = 1'b0;
    missed_d = missed_q;
    mult     = (state_q == StSqA) ? op_a_q : op_b_q;
    part     = mult[bit_q] ? ({{W{1'b0}}, mult} << bit_q) : '0;
    acc_next = acc_q + part;

    if (tick && (state_q != StIdle) && (missed_q != 8'hFF)) begin
      missed_d = missed_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (tick && enable) state_d = StLoad;
      end
      StLoad: begin
        op_a_d  = cnt_a_q;
        op_b_d  = cnt_b_q;
        acc_d   = '0;
        bit_d   = '0;
        state_d = StSqA;
      end
      StSqA, StSqB: begin
        if (bit_q == LastBit) begin
          acc_d = '0;
          bit_d = '0;
          if (state_q == StSqA) begin
            sq_a_d  = acc_next;
            state_d = StSqB;
          end else begin
            sq_b_d  = acc_next;
            state_d = StAdd;
          end
        end else begin
          acc_d = acc_next;
          bit_d = bit_q + 1'b1;
        end
      end
      StAdd: begin
        sum_d   = {1'b0, sq_a_q} + {1'b0, sq_b_q};
        state_d = StHold;
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
          if (cnt_b_q == '1) begin
            cnt_b_d = '0;
            if (cnt_a_q == '1) begin
              cnt_a_d = '0;
              wrap_d  = 1'b1;
            end else begin
              cnt_a_d = cnt_a_q + 1'b1;
            end
          end else begin
            cnt_b_d = cnt_b_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q  <= StIdle;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      edge_q   <= 1'b0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      acc_q    <= '0;
      sq_a_q   <= '0;
      sq_b_q   <= '0;
      sum_q    <= '0;
      bit_q    <= '0;
      wrap_q   <= 1'b0;
      missed_q <= '0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= slow_clk;
      sync2_q  <= sync1_q;
      edge_q   <= sync2_q;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      acc_q    <= acc_d;
      sq_a_q   <= sq_a_d;
      sq_b_q   <= sq_b_d;
      sum_q    <= sum_d;
      bit_q    <= bit_d;
      wrap_q   <= wrap_d;
      missed_q <= missed_d;
    end
  end

  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign sum          = sum_q;
  assign sum_valid    = (state_q == StHold);
  assign busy         = (state_q != StIdle);
  assign wrap         = wrap_q;
  assign missed_ticks = missed_q;

endmodule

// File: tb/tb_square_sum_stepper.sv
// Directed bench for square_sum_stepper: latency, full operand sweep, backpressure,
// mid-step reset, enable gating and missed-tick saturation.
module tb_square_sum_stepper;

  localparam int W = 4;

  logic         clk_in = 1'b0;
  logic         rst = 1'b1;
  logic         slow_clk = 1'b0;
  logic         enable = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] op_a, op_b;
  logic [2*W:0] sum;
  logic         sum_valid, busy, wrap;
  logic [7:0]   missed_ticks;

  int checks = 0;
  int failures = 0;

  square_sum_stepper #(.W(W)) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .slow_clk     (slow_clk),
    .enable       (enable),
    .out_ready    (out_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .sum          (sum),
    .sum_valid    (sum_valid),
    .busy         (busy),
    .wrap         (wrap),
    .missed_ticks (missed_ticks)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One slow_clk pulse: high 3 cycles, low 3 cycles.
  task automatic pulse_tick();
    @(negedge clk_in) slow_clk = 1'b1;
    repeat (3) @(negedge clk_in);
    slow_clk = 1'b0;
    repeat (3) @(negedge clk_in);
  endtask

  // Pulse, wait (bounded) for sum_valid, capture result, then observe wrap one cycle later.
  task automatic step(output logic [W-1:0] a, output logic [W-1:0] b, output logic [2*W:0] s,
                      output logic wr, output logic ok);
    ok = 1'b0;
    pulse_tick();
    for (int i = 0; i < 40; i++) begin
      if (sum_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_in);
    end
    a = op_a;
    b = op_b;
    s = sum;
    @(negedge clk_in);
    wr = wrap;
  endtask

  task automatic do_reset();
    @(negedge clk_in) rst = 1'b1;
    repeat (2) @(negedge clk_in);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(negedge clk_in);
    checks++;
    if ({op_a, op_b, sum} !== '0) begin
      failures++;
      $display("FAIL reset_data: got %0d/%0d/%0d expected 0/0/0", op_a, op_b, sum);
    end
    checks++;
    if ({sum_valid, busy, wrap} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 000", {sum_valid, busy, wrap});
    end
    checks++;
    if (missed_ticks !== 8'd0) begin
      failures++;
      $display("FAIL reset_missed: got %0d expected 0", missed_ticks);
    end
    rst = 1'b0;
  endtask

  task automatic test_first_steps();
    int lat;
    logic [W-1:0] a, b;
    logic [2*W:0] s;
    logic wr, ok;
    enable = 1'b1;
    out_ready = 1'b1;
    lat = 0;
    @(negedge clk_in) slow_clk = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk_in);
      if (n == 3) slow_clk = 1'b0;
      if (sum_valid) begin
        lat = n;
        break;
      end
    end
    slow_clk = 1'b0;
    // 2 synchronizer cycles until tick, then tick + 11 cycles to HOLD.
    checks++;
    if (lat != 13) begin
      failures++;
      $display("FAIL first_latency: got %0d expected 13", lat);
    end
    checks++;
    if ({op_a, op_b, sum} !== '0) begin
      failures++;
      $display("FAIL first_result: got %0d/%0d/%0d expected 0/0/0", op_a, op_b, sum);
    end
    @(negedge clk_in);
    checks++;
    if ({sum_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL hold_one_cycle: got valid/busy %b expected 00", {sum_valid, busy});
    end
    repeat (4) @(negedge clk_in);
    step(a, b, s, wr, ok);
    checks++;
    if (!ok || a !== 4'd0 || b !== 4'd1 || s !== 9'd1) begin
      failures++;
      $display("FAIL second_step: got ok=%0d %0d/%0d/%0d expected 1 0/1/1", ok, a, b, s);
    end
  endtask

  task automatic test_sequence();
    logic [W-1:0] a, b, ea, eb;
    logic [2*W:0] s, es;
    logic wr, ok;
    for (int ei = 2; ei <= 256; ei++) begin
      ea = 4'((ei % 256) / 16);
      eb = 4'(ei % 16);
      es = 9'(int'(ea) * int'(ea) + int'(eb) * int'(eb));
      step(a, b, s, wr, ok);
      checks++;
      if (!ok || a !== ea || b !== eb || s !== es || wr !== (ei == 255)) begin
        failures++;
        $display("FAIL sweep_%0d: got ok=%0d %0d/%0d/%0d wrap=%0d expected 1 %0d/%0d/%0d wrap=%0d",
                 ei, ok, a, b, s, wr, ea, eb, es, (ei == 255));
      end
      if (ei == 52) begin
        checks++;
        if (a !== 4'd3 || b !== 4'd4 || s !== 9'd25) begin
          failures++;
          $display("FAIL pair_3_4: got %0d/%0d/%0d expected 3/4/25", a, b, s);
        end
      end
      if (ei == 255) begin
        checks++;
        if (a !== 4'd15 || b !== 4'd15 || s !== 9'd450 || wr !== 1'b1) begin
          failures++;
          $display("FAIL pair_15_15: got %0d/%0d/%0d wrap=%0d expected 15/15/450 wrap=1",
                   a, b, s, wr);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, ca, cb;
    logic [2*W:0] s, cs;
    logic wr, ok, stable;
    do_reset();
    enable = 1'b1;
    out_ready = 1'b0;
    pulse_tick();
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sum_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_in);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL bp_valid: got valid=0 expected 1");
    end
    ca = op_a;
    cb = op_b;
    cs = sum;
    stable = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_in);
      slow_clk = (c < 130) && ((c % 40) >= 10) && ((c % 40) < 14);
      if (!sum_valid || op_a !== ca || op_b !== cb || sum !== cs) stable = 1'b0;
    end
    slow_clk = 1'b0;
    checks++;
    if (!stable || ca !== 4'd0 || cb !== 4'd0 || cs !== 9'd0) begin
      failures++;
      $display("FAIL bp_stable: got stable=%0d %0d/%0d/%0d expected 1 0/0/0", stable, ca, cb, cs);
    end
    checks++;
    if (missed_ticks !== 8'd3) begin
      failures++;
      $display("FAIL bp_missed: got %0d expected 3", missed_ticks);
    end
    out_ready = 1'b1;
    @(negedge clk_in);
    checks++;
    if (sum_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_single_transfer: got valid=%0d expected 0", sum_valid);
    end
    step(a, b, s, wr, ok);
    checks++;
    if (!ok || a !== 4'd0 || b !== 4'd1 || s !== 9'd1) begin
      failures++;
      $display("FAIL bp_next_pair: got ok=%0d %0d/%0d/%0d expected 1 0/1/1", ok, a, b, s);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] a, b;
    logic [2*W:0] s;
    logic wr, ok, leaked;
    out_ready = 1'b1;
    enable = 1'b1;
    @(negedge clk_in) slow_clk = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk_in);
      if (n == 3) slow_clk = 1'b0;
    end
    // Now in the second squaring phase.
    checks++;
    if (busy !== 1'b1 || sum_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_busy: got busy/valid %b expected 10", {busy, sum_valid});
    end
    rst = 1'b1;
    @(negedge clk_in);
    checks++;
    if ({op_a, op_b, sum, sum_valid, busy, wrap, missed_ticks} !== '0) begin
      failures++;
      $display("FAIL mid_reset: got %0d/%0d/%0d flags=%b missed=%0d expected all 0",
               op_a, op_b, sum, {sum_valid, busy, wrap}, missed_ticks);
    end
    rst = 1'b0;
    leaked = 1'b0;
    repeat (15) begin
      @(negedge clk_in);
      if (sum_valid || busy) leaked = 1'b1;
    end
    checks++;
    if (leaked) begin
      failures++;
      $display("FAIL mid_no_partial: got activity=1 expected 0");
    end
    step(a, b, s, wr, ok);
    checks++;
    if (!ok || a !== 4'd0 || b !== 4'd0 || s !== 9'd0) begin
      failures++;
      $display("FAIL mid_restart: got ok=%0d %0d/%0d/%0d expected 1 0/0/0", ok, a, b, s);
    end
  endtask

  task automatic test_enable_and_saturate();
    logic active;
    out_ready = 1'b0;
    enable = 1'b0;
    active = 1'b0;
    repeat (4) begin
      pulse_tick();
      if (sum_valid || busy) active = 1'b1;
    end
    repeat (20) begin
      @(negedge clk_in);
      if (sum_valid || busy) active = 1'b1;
    end
    checks++;
    if (active) begin
      failures++;
      $display("FAIL disabled_ticks: got activity=1 expected 0");
    end
    checks++;
    if (missed_ticks !== 8'd0) begin
      failures++;
      $display("FAIL disabled_missed: got %0d expected 0", missed_ticks);
    end
    enable = 1'b1;
    repeat (300) pulse_tick();
    checks++;
    if (missed_ticks !== 8'd255) begin
      failures++;
      $display("FAIL saturate: got %0d expected 255", missed_ticks);
    end
    checks++;
    if (sum_valid !== 1'b1 || op_a !== 4'd0 || op_b !== 4'd1 || sum !== 9'd1) begin
      failures++;
      $display("FAIL saturate_hold: got valid=%0d %0d/%0d/%0d expected 1 0/1/1",
               sum_valid, op_a, op_b, sum);
    end
  endtask

  initial begin
    test_reset();
    test_first_steps();
    test_sequence();
    test_backpressure();
    test_reset_mid();
    test_enable_and_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
